// File: rtl/frame_scan_ctrl.sv
// frame_scan_ctrl: raster scan sequencer. After a start request it offers one
// (col,row) beat per accepted handshake, walking IMG_W pixels per line and IMG_H
// lines per frame. It inserts LINE_GAP idle cycles between lines, then pulses
// frame_done for one cycle and counts the completed frame.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous active-high reset, clears all state
//   start_i        frame request, honoured only while idle
//   abort_i        synchronous abandon of the current frame
//   pix_ready_i    downstream accepts the offered beat
//   pix_valid_o    beat (col_o,row_o) is offered
//   col_o, row_o   current pixel column / line index
//   sof_o          beat at col=0,row=0
//   eol_o          beat at the last column
//   eof_o          beat at the last column of the last line
//   busy_o         high whenever not idle
//   frame_done_o   one-cycle pulse after the last beat of a completed frame
//   frame_cnt_o    completed-frame count, wraps at 16 bits
module frame_scan_ctrl #(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 640,
  parameter int unsigned LINE_GAP = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        pix_ready_i,
  output logic        pix_valid_o,
  output logic [9:0]  col_o,
  output logic [9:0]  row_o,
  output logic        sof_o,
  output logic        eol_o,
  output logic        eof_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o
);

  typedef enum logic [1:0] {StIdle, StScan, StGap, StDone} state_e;

  localparam logic [9:0] ColLast = 10'(IMG_W - 1);
  localparam logic [9:0] RowLast = 10'(IMG_H - 1);
  localparam bit         HasGap  = (LINE_GAP != 0);
  // With no gap the GAP state is unreachable, so the terminal value is irrelevant.
  localparam logic [7:0] GapLast = HasGap ? 8'(LINE_GAP - 1) : 8'd0;

  state_e      state_q, state_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        col_d = '0;
        row_d = '0;
        gap_d = '0;
        // Abort beats a simultaneous start.
        if (start_i && !abort_i) state_d = StScan;
      end
      StScan: begin
        if (abort_i) begin
          state_d = StIdle;
          col_d   = '0;
          row_d   = '0;
        end else if (pix_ready_i) begin
          if (col_q != ColLast) begin
            col_d = col_q + 10'd1;
          end else begin
            col_d = '0;
            gap_d = '0;
            if (row_q != RowLast) begin
              row_d   = row_q + 10'd1;
              state_d = HasGap ? StGap : StScan;
            end else begin
              row_d   = '0;
              state_d = StDone;
            end
          end
        end
      end
      StGap: begin
        if (abort_i) begin
          state_d = StIdle;
          col_d   = '0;
          row_d   = '0;
          gap_d   = '0;
        end else if (gap_q == GapLast) begin
          state_d = StScan;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        // An abort landing on the done cycle voids the frame.
        if (!abort_i) cnt_d = cnt_q + 16'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    pix_valid_o  = (state_q == StScan);
    busy_o       = (state_q != StIdle);
    frame_done_o = (state_q == StDone) && !abort_i;
    col_o        = col_q;
    row_o        = row_q;
    sof_o        = pix_valid_o && (col_q == '0) && (row_q == '0);
    eol_o        = pix_valid_o && (col_q == ColLast);
    eof_o        = eol_o && (row_q == RowLast);
    frame_cnt_o  = cnt_q;
  end

endmodule
